// File: rtl/keyed_mux4_lock_bank_pkg.sv
// Shared types and helpers for the keyed MUX4 lock bank: FSM state, key nibble size,
// and the signature fold applied to a committed key.
package lock_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } lock_state_e;

    localparam int MUX4_KEY_BITS = 4;
    localparam int MAX_KEY_W     = 256;

    // XOR of the first n_nib 4-bit nibbles; callers zero-extend their key to MAX_KEY_W.
    function automatic logic [3:0] nibble_xor_fold(input logic [MAX_KEY_W-1:0] key, input int n_nib);
        logic [3:0] acc;
        acc = 4'h0;
        for (int i = 0; i < MAX_KEY_W / 4; i++) begin
            if (i < n_nib) begin
                acc = acc ^ key[4*i +: 4];
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/keyed_mux4_lock_bank_if.sv
// Select/output and serial key-load signals of the lock bank. The master side is the
// key-load controller plus the locked core; the slave side is the bank itself.
interface keyed_mux4_lock_bank_if #(
    parameter int NUM_SITES = 8
);
    logic [NUM_SITES-1:0] sel_a;
    logic [NUM_SITES-1:0] sel_b;
    logic [NUM_SITES-1:0] site_out;
    logic                 key_start;
    logic                 key_abort;
    logic                 key_bit;
    logic                 key_bit_valid;
    logic                 key_bit_ready;
    logic                 key_done;
    logic                 key_loaded;
    logic [3:0]           key_sig;

    modport master (
        output sel_a, sel_b, key_start, key_abort, key_bit, key_bit_valid,
        input  site_out, key_bit_ready, key_done, key_loaded, key_sig
    );

    modport slave (
        input  sel_a, sel_b, key_start, key_abort, key_bit, key_bit_valid,
        output site_out, key_bit_ready, key_done, key_loaded, key_sig
    );
endinterface

// File: rtl/keyed_mux4_lock_bank_site.sv
// One keyed MUX4 lock site: {sel_b, sel_a} picks one of its four active key bits.
module keyed_mux4_site
    import lock_pkg::*;
(
    input  logic [MUX4_KEY_BITS-1:0] key_i,
    input  logic                     sel_a_i,
    input  logic                     sel_b_i,
    output logic                     out_o
);

    // 4:1 key-bit selection
    always_comb begin
        out_o = 1'b0;
        case ({sel_b_i, sel_a_i})
            2'b00:   out_o = key_i[0];
            2'b01:   out_o = key_i[1];
            2'b10:   out_o = key_i[2];
            2'b11:   out_o = key_i[3];
            default: out_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/keyed_mux4_lock_bank.sv
// Bank of keyed MUX4 lock sites. A serially loaded shadow key is committed atomically
// into the active key, so sites only ever see complete keys.
module keyed_mux4_lock_bank
    import lock_pkg::*;
#(
    parameter int NUM_SITES = 8,
    parameter int OUT_REG   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    keyed_mux4_lock_bank_if.slave   bus
);

    localparam int                KEY_W    = MUX4_KEY_BITS * NUM_SITES;
    localparam int                CNT_W    = $clog2(KEY_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(KEY_W - 1);

    lock_state_e          state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [KEY_W-1:0]     shadow_q;
    logic [KEY_W-1:0]     active_q;
    logic [3:0]           sig_q;
    logic                 ready_q;
    logic                 done_q;
    logic                 loaded_q;
    logic [NUM_SITES-1:0] mux_d;

    // Key-load FSM; abort wins over a bit presented in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
            sig_q    <= 4'h0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            loaded_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b0;
                    if (bus.key_start && !bus.key_abort) begin
                        state_q  <= SHIFT;
                        cnt_q    <= '0;
                        shadow_q <= '0;
                        ready_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (bus.key_abort) begin
                        state_q  <= IDLE;
                        cnt_q    <= '0;
                        shadow_q <= '0;
                        ready_q  <= 1'b0;
                    end else if (bus.key_bit_valid) begin
                        shadow_q[cnt_q] <= bus.key_bit;
                        if (cnt_q == CNT_LAST) begin
                            state_q <= COMMIT;
                            ready_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    active_q <= shadow_q;
                    sig_q    <= nibble_xor_fold(MAX_KEY_W'(shadow_q), NUM_SITES);
                    loaded_q <= 1'b1;
                    done_q   <= 1'b0;
                    ready_q  <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NUM_SITES; i++) begin : g_site
        keyed_mux4_site u_site (
            .key_i   (active_q[MUX4_KEY_BITS*i +: MUX4_KEY_BITS]),
            .sel_a_i (bus.sel_a[i]),
            .sel_b_i (bus.sel_b[i]),
            .out_o   (mux_d[i])
        );
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [NUM_SITES-1:0] site_q;

        // Optional retiming stage on the site outputs
        always_ff @(posedge clk) begin
            if (rst) begin
                site_q <= '0;
            end else begin
                site_q <= mux_d;
            end
        end
        assign bus.site_out = site_q;
    end else begin : g_out_comb
        assign bus.site_out = mux_d;
    end

    assign bus.key_bit_ready = ready_q;
    assign bus.key_done      = done_q;
    assign bus.key_loaded    = loaded_q;
    assign bus.key_sig       = sig_q;

endmodule
